// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter: round-robin controller sharing one WIDTH-bit adder among N_REQ requesters.
// Define ADDER_SHARE_PIPE_EN to add state CALC2 with a register after the adder (3-cycle latency).
module adder_share_arbiter #(
   parameter int WIDTH = 16,
   parameter int N_REQ = 4
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic [N_REQ-1:0]         i_req,
   input  logic [N_REQ*WIDTH-1:0]   i_op_a,
   input  logic [N_REQ*WIDTH-1:0]   i_op_b,
   output logic [N_REQ-1:0]         o_gnt,
   output logic                     o_busy,
   output logic                     o_valid,
   output logic [WIDTH:0]           o_result,
   output logic [$clog2(N_REQ)-1:0] o_id,
   input  logic                     i_ack
);
   localparam int IW = $clog2(N_REQ);
`ifdef ADDER_SHARE_PIPE_EN
   typedef enum logic [1:0] {IDLE, CALC, CALC2, DONE} state_t;
`else
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
`endif
   state_t r_state, w_next;
   logic [IW-1:0] r_ptr, r_id, r_oid, w_win, w_cand;
   logic w_any;
   logic [WIDTH-1:0] r_a, r_b;
   logic [WIDTH:0] w_sum, r_res;
`ifdef ADDER_SHARE_PIPE_EN
   logic [WIDTH:0] r_sum;
`endif
   // Scan from the highest offset down so the lowest offset from r_ptr wins.
   always_comb begin
      w_win = r_ptr;
      w_any = 1'b0;
      w_cand = r_ptr;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         w_cand = r_ptr + IW'(i);
         if (i_req[w_cand]) begin
            w_win = w_cand;
            w_any = 1'b1;
         end
      end
   end
   assign w_sum = {1'b0, r_a} + {1'b0, r_b};
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = w_any ? CALC : IDLE;
`ifdef ADDER_SHARE_PIPE_EN
         CALC:    w_next = CALC2;
         CALC2:   w_next = DONE;
`else
         CALC:    w_next = DONE;
`endif
         DONE:    w_next = i_ack ? IDLE : DONE;
         default: w_next = IDLE;
      endcase
   end
   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= IDLE;
      else r_state <= w_next;
   end
   always_ff @(posedge i_clk) begin
      if (r_state == IDLE && w_any) begin
         r_a <= i_op_a[w_win*WIDTH +: WIDTH];
         r_b <= i_op_b[w_win*WIDTH +: WIDTH];
         r_id <= w_win;
      end
`ifdef ADDER_SHARE_PIPE_EN
      if (r_state == CALC) r_sum <= w_sum;
`endif
   end
   // Result and its owner ID load together, so o_id only changes with o_result.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_ptr <= '0;
         r_res <= '0;
         r_oid <= '0;
      end else begin
`ifdef ADDER_SHARE_PIPE_EN
         if (r_state == CALC2) begin
            r_res <= r_sum;
            r_oid <= r_id;
         end
`else
         if (r_state == CALC) begin
            r_res <= w_sum;
            r_oid <= r_id;
         end
`endif
         if (r_state == DONE && i_ack) r_ptr <= r_id + 1'b1;
      end
   end
   assign o_gnt = (r_state == IDLE && w_any && !i_rst) ? N_REQ'(1) << w_win : '0;
   assign o_busy = r_state != IDLE;
   assign o_valid = r_state == DONE;
   assign o_result = r_res;
   assign o_id = r_oid;
endmodule

// File: tb/tb_adder_share_arbiter.sv
// tb_adder_share_arbiter: randomized and directed checks against a transaction-level model.
module tb_adder_share_arbiter;
   localparam int W = 16;
   localparam int N = 4;
`ifdef ADDER_SHARE_PIPE_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 2;
`endif
   logic clk = 1'b0;
   logic i_rst, i_ack;
   logic [N-1:0] i_req, o_gnt;
   logic [N*W-1:0] i_op_a, i_op_b;
   logic o_busy, o_valid;
   logic [W:0] o_result;
   logic [$clog2(N)-1:0] o_id;
   adder_share_arbiter #(.WIDTH(W), .N_REQ(N)) dut (
      .i_clk(clk), .i_rst(i_rst), .i_req(i_req), .i_op_a(i_op_a), .i_op_b(i_op_b),
      .o_gnt(o_gnt), .o_busy(o_busy), .o_valid(o_valid), .o_result(o_result),
      .o_id(o_id), .i_ack(i_ack));
   always #5 clk = ~clk;
   int n_tests = 0, n_fail = 0, cyc = 0, g_last = -1;
   logic d_rst, d_ack;
   logic [N-1:0] d_req;
   logic [W-1:0] d_a [N], d_b [N];
   bit m_pend = 0;
   int m_age = 0, m_ptr = 0, m_id = 0, m_nid = 0;
   logic [W:0] m_res = '0, m_nres = '0;
   int q_win[$], q_t[$];
   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask
   function automatic logic [W-1:0] rnd_op();
      return ($urandom % 3 == 0) ? W'(16'hFFFF - $urandom_range(0, 3)) : W'($urandom);
   endfunction
   task automatic cycle();
      logic [N-1:0] eg;
      logic ev;
      int win;
      i_rst = d_rst;
      i_req = d_req;
      i_ack = d_ack;
      for (int k = 0; k < N; k++) begin
         i_op_a[k*W +: W] = d_a[k];
         i_op_b[k*W +: W] = d_b[k];
      end
      @(negedge clk);
      ev = m_pend && m_age >= LAT;
      win = -1;
      if (!d_rst && !m_pend)
         for (int k = 0; k < N; k++)
            if (win < 0 && d_req[(m_ptr + k) % N]) win = (m_ptr + k) % N;
      eg = '0;
      if (win >= 0) eg[win] = 1'b1;
      check("gnt", o_gnt, eg);
      check("valid", o_valid, ev);
      check("busy", o_busy, m_pend);
      check("result", o_result, m_res);
      check("id", o_id, m_id);
      g_last = win;
      if (win >= 0) begin
         q_win.push_back(win);
         q_t.push_back(cyc);
      end
      @(posedge clk);
      if (d_rst) begin
         m_pend = 0; m_ptr = 0; m_res = '0; m_id = 0;
      end else if (!m_pend) begin
         if (win >= 0) begin
            m_pend = 1;
            m_age = 1;
            m_nres = {1'b0, d_a[win]} + {1'b0, d_b[win]};
            m_nid = win;
            if (m_age == LAT) begin m_res = m_nres; m_id = m_nid; end
         end
      end else if (ev) begin
         if (d_ack) begin m_pend = 0; m_ptr = (m_nid + 1) % N; end
      end else begin
         m_age++;
         if (m_age == LAT) begin m_res = m_nres; m_id = m_nid; end
      end
      cyc++;
      #1;
   endtask
   task automatic txn(int k, logic [W-1:0] a, logic [W-1:0] b, logic [W:0] exp);
      int t = 0;
      d_req = '0; d_req[k] = 1'b1; d_a[k] = a; d_b[k] = b; d_ack = 1'b0;
      do begin cycle(); t++; end while (g_last != k && t < 20);
      check("txn_gnt", g_last, k);
      d_req = '0;
      t = 0;
      while (!(m_pend && m_age >= LAT) && t < 20) begin cycle(); t++; end
      check("txn_latency", t, LAT - 1);
      check("txn_sum", o_result, exp);
      check("txn_id", o_id, k);
      d_ack = 1'b1; cycle(); d_ack = 1'b0;
      check("txn_idle", o_busy, 0);
   endtask
   task automatic wait_state(int age);
      int t = 0;
      while (!(m_pend && m_age >= age) && t < 20) begin cycle(); t++; if (g_last >= 0) d_req[g_last] = 1'b0; end
      check("wait_bound", t < 20, 1);
   endtask
   initial begin
      d_rst = 1'b1; d_ack = 1'b0; d_req = '1;
      for (int k = 0; k < N; k++) begin d_a[k] = '0; d_b[k] = '0; end
      i_rst = 1'b1; i_req = '1; i_ack = 1'b0; i_op_a = '0; i_op_b = '0;
      @(posedge clk); #1;
      repeat (2) cycle();
      d_rst = 1'b0;
      cycle();
      check("first_gnt", g_last, 0);
      d_req = '0; d_ack = 1'b1;
      repeat (LAT + 1) cycle();
      d_ack = 1'b0;
      txn(1, 16'h0000, 16'h0001, 17'h00001);
      txn(0, 16'h0002, 16'hFFFE, 17'h10000);
      txn(0, 16'hFFFD, 16'hFFFE, 17'h1FFFB);
      txn(0, 16'hFFFF, 16'h0001, 17'h10000);
      // Round-robin with everyone requesting and ack tied high.
      d_rst = 1'b1; cycle(); d_rst = 1'b0;
      q_win.delete(); q_t.delete();
      d_req = '1; d_ack = 1'b1;
      for (int k = 0; k < N; k++) begin d_a[k] = rnd_op(); d_b[k] = rnd_op(); end
      repeat (5 * (LAT + 1)) cycle();
      check("rr_count", q_win.size(), 5);
      for (int i = 0; i < 5 && i < q_win.size(); i++) begin
         check("rr_order", q_win[i], i % N);
         if (i > 0) check("rr_spacing", q_t[i] - q_t[i-1], LAT + 1);
      end
      d_req = '0;
      repeat (LAT + 1) cycle();
      // Backpressure: hold ack low in DONE while inputs churn.
      d_ack = 1'b0; d_req = 4'b0100; d_a[2] = 16'hABCD; d_b[2] = 16'h9876;
      wait_state(LAT);
      check("bp_res", o_result, 17'h14443);
      repeat (10) begin
         d_req = N'($urandom);
         for (int k = 0; k < N; k++) begin d_a[k] = rnd_op(); d_b[k] = rnd_op(); end
         cycle();
      end
      check("bp_hold", o_result, 17'h14443);
      check("bp_id", o_id, 2);
      d_ack = 1'b1; d_req = '0; cycle(); d_ack = 1'b0;
      cycle();
      check("bp_released", o_busy, 0);
      // Reset in CALC, then in DONE together with ack.
      d_req = 4'b1000; d_a[3] = 16'h1111; d_b[3] = 16'h2222;
      wait_state(1);
      d_rst = 1'b1; cycle(); d_rst = 1'b0;
      check("rst_calc_valid", o_valid, 0);
      d_req = '1;
      cycle();
      check("rst_calc_gnt", g_last, 0);
      d_req = '0;
      wait_state(LAT);
      d_rst = 1'b1; d_ack = 1'b1; cycle(); d_rst = 1'b0; d_ack = 1'b0;
      check("rst_done_res", o_result, 0);
      d_req = 4'b1010;
      cycle();
      check("rst_done_gnt", g_last, 1);
      d_req = '0;
      d_ack = 1'b1; repeat (LAT + 1) cycle();
      // Randomized traffic obeying the requester protocol.
      for (int n = 0; n < 600; n++) begin
         for (int k = 0; k < N; k++) begin
            if (!d_req[k] && $urandom % 4 == 0) begin
               d_req[k] = 1'b1; d_a[k] = rnd_op(); d_b[k] = rnd_op();
            end else if (d_req[k] && $urandom % 40 == 0) d_req[k] = 1'b0;
         end
         d_ack = ($urandom % 3) != 0;
         d_rst = ($urandom % 100) == 0;
         cycle();
         if (g_last >= 0) d_req[g_last] = 1'b0;
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
